// File: rtl/cp0_regfile_if.sv
`timescale 1ns/1ps
// cp0_regfile_if
// Bundles the CP0 register-file traffic between the pipeline and CP0:
//   - MTC0 write port (from WB)
//   - MFC0 read port (address from EXE, data back)
//   - hardware interrupt lines
//   - exception / ERET commit (from MEM)
//   - flush redirect and interrupt request outputs
// master: pipeline side (drives requests, receives read data / flush / int_req)
// slave : CP0 side
interface cp0_regfile_if;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic [5:0]  int_i;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic [31:0] exc_badvaddr;
    logic        exc_in_ds;
    logic        eret;
    logic        flush;
    logic [31:0] flush_pc;
    logic        int_req;

    modport master (
        output cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, int_i,
               exc_valid, exc_code, exc_pc, exc_badvaddr, exc_in_ds, eret,
        input  cp0_rdata, flush, flush_pc, int_req
    );

    modport slave (
        input  cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, int_i,
               exc_valid, exc_code, exc_pc, exc_badvaddr, exc_in_ds, eret,
        output cp0_rdata, flush, flush_pc, int_req
    );
endinterface

// File: rtl/cp0_regfile.sv
`timescale 1ns/1ps
// cp0_regfile
// Coprocessor-0 register file: BadVAddr(8), Count(9), Compare(11), Status(12),
// Cause(13), EPC(14). Runs the half-rate Count/Compare timer, commits MTC0
// writes and exception/ERET events, and produces flush redirect and the
// interrupt request.
// Ports:
//   clk  - core clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - cp0_regfile_if.slave: MTC0 write, MFC0 read, int_i,
//          exception/ERET commit inputs; cp0_rdata, flush, flush_pc, int_req out
module cp0_regfile #(
    parameter logic [31:0] EXC_ENTRY  = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input logic          clk,
    input logic          rst,
    cp0_regfile_if.slave bus
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    // Architectural state, kept as individual fields; read-as-zero bits are
    // not stored at all.
    logic [31:0] badvaddr_r, badvaddr_s;
    logic [31:0] count_r,    count_s;
    logic [31:0] compare_r,  compare_s;
    logic [31:0] epc_r,      epc_s;
    logic [7:0]  im_r,       im_s;
    logic        exl_r,      exl_s;
    logic        ie_r,       ie_s;
    logic        bd_r,       bd_s;
    logic        ti_r,       ti_s;
    logic [4:0]  exccode_r,  exccode_s;
    logic [5:0]  ip_hw_r,    ip_hw_s;
    logic [1:0]  ip_sw_r,    ip_sw_s;
    logic        tick_r,     tick_s;

    logic [31:0] status_view_s;
    logic [31:0] cause_view_s;
    logic [31:0] rdata_s;
    logic [31:0] flush_pc_s;

    assign status_view_s = {9'd0, 1'b1, 6'd0, im_r, 6'd0, exl_r, ie_r};
    assign cause_view_s  = {bd_r, ti_r, 14'd0, ip_hw_r, ip_sw_r, 1'b0, exccode_r, 2'b00};

    // Next-state: timer first, then MTC0, then exception/ERET so that the
    // later stages override only the fields they own.
    always_comb begin
        badvaddr_s = badvaddr_r;
        compare_s  = compare_r;
        epc_s      = epc_r;
        im_s       = im_r;
        exl_s      = exl_r;
        ie_s       = ie_r;
        bd_s       = bd_r;
        exccode_s  = exccode_r;
        ip_sw_s    = ip_sw_r;
        tick_s     = ~tick_r;
        // IP7 carries the timer interrupt alongside int_i[5]
        ip_hw_s    = {bus.int_i[5] | ti_r, bus.int_i[4:0]};

        if (tick_r) begin
            count_s = count_r + 32'd1;
        end else begin
            count_s = count_r;
        end

        // sticky until software rewrites Compare
        if (count_r == compare_r) begin
            ti_s = 1'b1;
        end else begin
            ti_s = ti_r;
        end

        if (bus.cp0_we) begin
            case (bus.cp0_waddr)
                REG_COUNT: begin
                    count_s = bus.cp0_wdata;
                end
                REG_COMPARE: begin
                    compare_s = bus.cp0_wdata;
                    ti_s      = 1'b0;
                end
                REG_STATUS: begin
                    im_s  = bus.cp0_wdata[15:8];
                    exl_s = bus.cp0_wdata[1];
                    ie_s  = bus.cp0_wdata[0];
                end
                REG_CAUSE: begin
                    ip_sw_s = bus.cp0_wdata[9:8];
                end
                REG_EPC: begin
                    epc_s = bus.cp0_wdata;
                end
                default: begin
                    // BadVAddr and unmapped registers ignore writes
                end
            endcase
        end else begin
            // no software write this cycle
        end

        if (bus.exc_valid) begin
            exl_s     = 1'b1;
            exccode_s = bus.exc_code;
            // a nested exception keeps the original return point
            if (!exl_r) begin
                epc_s = bus.exc_in_ds ? (bus.exc_pc - 32'd4) : bus.exc_pc;
                bd_s  = bus.exc_in_ds;
            end else begin
                // EPC/BD preserved
            end
            if ((bus.exc_code == EXC_ADEL) || (bus.exc_code == EXC_ADES)) begin
                badvaddr_s = bus.exc_badvaddr;
            end else begin
                // BadVAddr preserved
            end
        end else if (bus.eret) begin
            exl_s = 1'b0;
        end else begin
            // no exception event this cycle
        end
    end

    // State register with synchronous reset taking priority over every update
    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr_r <= 32'd0;
            count_r    <= 32'd0;
            compare_r  <= 32'd0;
            epc_r      <= 32'd0;
            im_r       <= STATUS_RST[15:8];
            exl_r      <= STATUS_RST[1];
            ie_r       <= STATUS_RST[0];
            bd_r       <= 1'b0;
            ti_r       <= 1'b0;
            exccode_r  <= 5'd0;
            ip_hw_r    <= 6'd0;
            ip_sw_r    <= 2'd0;
            tick_r     <= 1'b0;
        end else begin
            badvaddr_r <= badvaddr_s;
            count_r    <= count_s;
            compare_r  <= compare_s;
            epc_r      <= epc_s;
            im_r       <= im_s;
            exl_r      <= exl_s;
            ie_r       <= ie_s;
            bd_r       <= bd_s;
            ti_r       <= ti_s;
            exccode_r  <= exccode_s;
            ip_hw_r    <= ip_hw_s;
            ip_sw_r    <= ip_sw_s;
            tick_r     <= tick_s;
        end
    end

    // MFC0 read mux over registered values (no internal bypass)
    always_comb begin
        rdata_s = 32'd0;
        case (bus.cp0_raddr)
            REG_BADVADDR: rdata_s = badvaddr_r;
            REG_COUNT:    rdata_s = count_r;
            REG_COMPARE:  rdata_s = compare_r;
            REG_STATUS:   rdata_s = status_view_s;
            REG_CAUSE:    rdata_s = cause_view_s;
            REG_EPC:      rdata_s = epc_r;
            default:      rdata_s = 32'd0;
        endcase
    end

    // Flush target; ERET picks up an EPC being written by MTC0 in the same cycle
    always_comb begin
        flush_pc_s = 32'd0;
        if (bus.exc_valid) begin
            flush_pc_s = EXC_ENTRY;
        end else if (bus.eret) begin
            if (bus.cp0_we && (bus.cp0_waddr == REG_EPC)) begin
                flush_pc_s = bus.cp0_wdata;
            end else begin
                flush_pc_s = epc_r;
            end
        end else begin
            flush_pc_s = 32'd0;
        end
    end

    assign bus.cp0_rdata = rdata_s;
    assign bus.flush     = bus.exc_valid | bus.eret;
    assign bus.flush_pc  = flush_pc_s;
    assign bus.int_req   = ie_r & ~exl_r & (|({ip_hw_r, ip_sw_r} & im_r));

endmodule

// File: tb/tb_cp0_regfile.sv
`timescale 1ns/1ps
module tb_cp0_regfile;

    logic clk = 1'b0;
    logic rst;

    always #10 clk = ~clk;

    cp0_regfile_if bus();

    cp0_regfile #(
        .EXC_ENTRY  (32'hBFC0_0380),
        .STATUS_RST (32'h0040_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: software-visible 32-bit register images indexed by
    // CP0 register number, plus the half-rate tick.
    logic [31:0] m_reg [0:31];
    logic        m_tick = 1'b0;
    logic        m_ok   = 1'b0;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [5:0]  int_i;
        logic        exc;
        logic [4:0]  code;
        logic [31:0] pc;
        logic [31:0] bva;
        logic        ds;
        logic        eret;
        logic        exp_flush;
        logic [31:0] exp_fpc;
        logic [4:0]  raddr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [0:18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd8 || a == 5'd9 || a == 5'd11 || a == 5'd12 || a == 5'd13 || a == 5'd14)
            return m_reg[a];
        return 32'd0;
    endfunction

    function automatic logic model_irq();
        logic [31:0] st;
        logic [31:0] ca;
        st = m_reg[12];
        ca = m_reg[13];
        return st[0] & ~st[1] & (|(ca[15:8] & st[15:8]));
    endfunction

    function automatic logic [31:0] model_fpc();
        if (bus.exc_valid) return 32'hBFC0_0380;
        if (bus.eret) return (bus.cp0_we && bus.cp0_waddr == 5'd14) ? bus.cp0_wdata : m_reg[14];
        return 32'd0;
    endfunction

    task automatic model_update();
        logic [31:0] o [0:31];
        logic [31:0] n [0:31];
        o = m_reg;
        n = m_reg;
        if (rst) begin
            for (int i = 0; i < 32; i++) n[i] = 32'd0;
            n[12] = 32'h0040_0000;
            m_tick = 1'b0;
            m_ok = 1'b1;
        end else begin
            if (m_tick) n[9] = o[9] + 32'd1;
            m_tick = ~m_tick;
            if (o[9] == o[11]) n[13][30] = 1'b1;
            n[13][15:10] = {bus.int_i[5] | o[13][30], bus.int_i[4:0]};
            if (bus.cp0_we) begin
                case (bus.cp0_waddr)
                    5'd9:  n[9] = bus.cp0_wdata;
                    5'd11: begin n[11] = bus.cp0_wdata; n[13][30] = 1'b0; end
                    5'd12: n[12] = (bus.cp0_wdata & 32'h0000_FF03) | 32'h0040_0000;
                    5'd13: n[13] = (n[13] & ~32'h0000_0300) | (bus.cp0_wdata & 32'h0000_0300);
                    5'd14: n[14] = bus.cp0_wdata;
                    default: ;
                endcase
            end
            if (bus.exc_valid) begin
                n[12][1] = 1'b1;
                n[13][6:2] = bus.exc_code;
                if (!o[12][1]) begin
                    n[14] = bus.exc_in_ds ? bus.exc_pc - 32'd4 : bus.exc_pc;
                    n[13][31] = bus.exc_in_ds;
                end
                if (bus.exc_code == 5'h04 || bus.exc_code == 5'h05) n[8] = bus.exc_badvaddr;
            end else if (bus.eret) begin
                n[12][1] = 1'b0;
            end
        end
        m_reg = n;
    endtask

    task automatic model_check();
        chk("m_rdata",    bus.cp0_rdata, model_read(bus.cp0_raddr));
        chk("m_flush",    {31'd0, bus.flush}, {31'd0, bus.exc_valid | bus.eret});
        chk("m_flush_pc", bus.flush_pc, model_fpc());
        chk("m_int_req",  {31'd0, bus.int_req}, {31'd0, model_irq()});
    endtask

    task automatic step();
        @(negedge clk);
        if (m_ok) model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_idle();
        bus.cp0_we       = 1'b0;
        bus.cp0_waddr    = 5'd0;
        bus.cp0_wdata    = 32'd0;
        bus.int_i        = 6'd0;
        bus.exc_valid    = 1'b0;
        bus.exc_code     = 5'd0;
        bus.exc_pc       = 32'd0;
        bus.exc_badvaddr = 32'd0;
        bus.exc_in_ds    = 1'b0;
        bus.eret         = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [4:0] a, input logic [31:0] exp);
        bus.cp0_raddr = a;
        #1;
        chk(nm, bus.cp0_rdata, exp);
    endtask

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [5:0] ii, input logic ex, input logic [4:0] cd,
                                input logic [31:0] pc, input logic [31:0] bva, input logic ds,
                                input logic er, input logic ef, input logic [31:0] efpc,
                                input logic [4:0] ra, input logic [31:0] erd, input logic eirq);
        vec_t v;
        v.we = we; v.waddr = wa; v.wdata = wd; v.int_i = ii; v.exc = ex; v.code = cd;
        v.pc = pc; v.bva = bva; v.ds = ds; v.eret = er; v.exp_flush = ef; v.exp_fpc = efpc;
        v.raddr = ra; v.exp_rd = erd; v.exp_irq = eirq;
        return v;
    endfunction

    initial begin
        logic [4:0] wa;
        logic [31:0] wd;

        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;

        //            we   wa     wdata          int_i  exc  code   pc             bva            ds   eret flush fpc            ra     rd             irq
        tbl[0]  = mk(1'b1, 5'd12, 32'h0000_0401, 6'd1, 1'b0, 5'h00, 32'd0,         32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         5'd12, 32'h0040_0401, 1'b1);
        tbl[1]  = mk(1'b1, 5'd12, 32'h0000_0403, 6'd1, 1'b0, 5'h00, 32'd0,         32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         5'd12, 32'h0040_0403, 1'b0);
        tbl[2]  = mk(1'b1, 5'd12, 32'h0000_0000, 6'd0, 1'b0, 5'h00, 32'd0,         32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         5'd12, 32'h0040_0000, 1'b0);
        tbl[3]  = mk(1'b0, 5'd0,  32'd0,         6'd0, 1'b1, 5'h04, 32'h8000_0104, 32'h0000_0003, 1'b1, 1'b0, 1'b1, 32'hBFC0_0380, 5'd14, 32'h8000_0100, 1'b0);
        tbl[4]  = mk(1'b0, 5'd0,  32'd0,         6'd0, 1'b0, 5'h00, 32'd0,         32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         5'd13, 32'h8000_0010, 1'b0);
        tbl[5]  = mk(1'b0, 5'd0,  32'd0,         6'd0, 1'b0, 5'h00, 32'd0,         32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         5'd8,  32'h0000_0003, 1'b0);
        tbl[6]  = mk(1'b0, 5'd0,  32'd0,         6'd0, 1'b0, 5'h00, 32'd0,         32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         5'd12, 32'h0040_0002, 1'b0);
        tbl[7]  = mk(1'b0, 5'd0,  32'd0,         6'd0, 1'b1, 5'h0D, 32'h8000_0200, 32'h0000_DEAD, 1'b0, 1'b0, 1'b1, 32'hBFC0_0380, 5'd14, 32'h8000_0100, 1'b0);
        tbl[8]  = mk(1'b0, 5'd0,  32'd0,         6'd0, 1'b0, 5'h00, 32'd0,         32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         5'd13, 32'h8000_0034, 1'b0);
        tbl[9]  = mk(1'b0, 5'd0,  32'd0,         6'd0, 1'b0, 5'h00, 32'd0,         32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         5'd8,  32'h0000_0003, 1'b0);
        tbl[10] = mk(1'b1, 5'd14, 32'h8000_1000, 6'd0, 1'b0, 5'h00, 32'd0,         32'd0,         1'b0, 1'b1, 1'b1, 32'h8000_1000, 5'd12, 32'h0040_0000, 1'b0);
        tbl[11] = mk(1'b0, 5'd0,  32'd0,         6'd0, 1'b0, 5'h00, 32'd0,         32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         5'd14, 32'h8000_1000, 1'b0);
        tbl[12] = mk(1'b0, 5'd0,  32'd0,         6'd0, 1'b0, 5'h00, 32'd0,         32'd0,         1'b0, 1'b1, 1'b1, 32'h8000_1000, 5'd12, 32'h0040_0000, 1'b0);
        tbl[13] = mk(1'b0, 5'd0,  32'd0,         6'd0, 1'b1, 5'h05, 32'h8000_0300, 32'h0000_0044, 1'b0, 1'b1, 1'b1, 32'hBFC0_0380, 5'd8,  32'h0000_0044, 1'b0);
        tbl[14] = mk(1'b0, 5'd0,  32'd0,         6'd0, 1'b0, 5'h00, 32'd0,         32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         5'd14, 32'h8000_0300, 1'b0);
        tbl[15] = mk(1'b1, 5'd14, 32'h1234_5678, 6'd0, 1'b1, 5'h00, 32'h8000_0400, 32'd0,         1'b0, 1'b0, 1'b1, 32'hBFC0_0380, 5'd14, 32'h1234_5678, 1'b0);
        tbl[16] = mk(1'b1, 5'd8,  32'hFFFF_FFFF, 6'd0, 1'b0, 5'h00, 32'd0,         32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         5'd8,  32'h0000_0044, 1'b0);
        tbl[17] = mk(1'b1, 5'd13, 32'hFFFF_FFFF, 6'd0, 1'b0, 5'h00, 32'd0,         32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         5'd13, 32'h0000_0300, 1'b0);
        tbl[18] = mk(1'b1, 5'd20, 32'hFFFF_FFFF, 6'd0, 1'b0, 5'h00, 32'd0,         32'd0,         1'b0, 1'b0, 1'b0, 32'd0,         5'd20, 32'h0000_0000, 1'b0);

        // reset held two edges
        set_idle();
        bus.cp0_raddr = 5'd0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        rd("rst_status", 5'd12, 32'h0040_0000);
        rd("rst_cause",  5'd13, 32'd0);
        rd("rst_epc",    5'd14, 32'd0);
        rd("rst_count",  5'd9,  32'd0);
        chk("rst_int_req", {31'd0, bus.int_req}, 32'd0);
        chk("rst_flush_pc", bus.flush_pc, 32'd0);

        // timer: Compare=5, Count reaches 5 after 10 edges, TI one edge later
        bus.cp0_we = 1'b1; bus.cp0_waddr = 5'd11; bus.cp0_wdata = 32'd5;
        step();
        set_idle();
        repeat (9) step();
        rd("tmr_count5", 5'd9, 32'd5);
        rd("tmr_ti_clear", 5'd13, 32'd0);
        step();
        rd("tmr_ti_set", 5'd13, 32'h4000_0000);
        bus.cp0_we = 1'b1; bus.cp0_waddr = 5'd11; bus.cp0_wdata = 32'd100;
        step();
        set_idle();
        rd("tmr_ti_cleared", 5'd13, 32'h0000_8000);
        rd("tmr_compare", 5'd11, 32'd100);

        // table vectors: interrupt, exceptions, ERET, write masking
        for (int i = 0; i < 19; i++) begin
            bus.cp0_we       = tbl[i].we;
            bus.cp0_waddr    = tbl[i].waddr;
            bus.cp0_wdata    = tbl[i].wdata;
            bus.int_i        = tbl[i].int_i;
            bus.exc_valid    = tbl[i].exc;
            bus.exc_code     = tbl[i].code;
            bus.exc_pc       = tbl[i].pc;
            bus.exc_badvaddr = tbl[i].bva;
            bus.exc_in_ds    = tbl[i].ds;
            bus.eret         = tbl[i].eret;
            #1;
            chk($sformatf("tbl%0d_flush", i), {31'd0, bus.flush}, {31'd0, tbl[i].exp_flush});
            chk($sformatf("tbl%0d_flush_pc", i), bus.flush_pc, tbl[i].exp_fpc);
            step();
            set_idle();
            bus.int_i = tbl[i].int_i;
            rd($sformatf("tbl%0d_rdata", i), tbl[i].raddr, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_int_req", i), {31'd0, bus.int_req}, {31'd0, tbl[i].exp_irq});
        end

        // randomized traffic against the reference model
        for (int c = 0; c < 4000; c++) begin
            set_idle();
            rst = ($urandom_range(199, 0) == 0);
            bus.int_i = ($urandom_range(3, 0) == 0) ? 6'($urandom) : 6'd0;
            if ($urandom_range(9, 0) < 3) begin
                case ($urandom_range(7, 0))
                    0: wa = 5'd8;
                    1: wa = 5'd9;
                    2: wa = 5'd11;
                    3: wa = 5'd12;
                    4: wa = 5'd13;
                    5: wa = 5'd14;
                    6: wa = 5'd0;
                    default: wa = 5'd20;
                endcase
                wd = $urandom;
                if (wa == 5'd9 && $urandom_range(3, 0) == 0) wd = 32'hFFFF_FFFE;
                if (wa == 5'd11 && $urandom_range(1, 0) == 0) wd = m_reg[9] + 32'($urandom_range(4, 0));
                bus.cp0_we = 1'b1;
                bus.cp0_waddr = wa;
                bus.cp0_wdata = wd;
            end
            if ($urandom_range(19, 0) == 0) begin
                bus.exc_valid    = 1'b1;
                bus.exc_code     = ($urandom_range(1, 0) == 0) ? 5'($urandom_range(5, 4)) : 5'($urandom);
                bus.exc_pc       = $urandom;
                bus.exc_badvaddr = $urandom;
                bus.exc_in_ds    = 1'($urandom);
            end
            if ($urandom_range(19, 0) == 0) bus.eret = 1'b1;
            case ($urandom_range(6, 0))
                0: bus.cp0_raddr = 5'd8;
                1: bus.cp0_raddr = 5'd9;
                2: bus.cp0_raddr = 5'd11;
                3: bus.cp0_raddr = 5'd12;
                4: bus.cp0_raddr = 5'd13;
                5: bus.cp0_raddr = 5'd14;
                default: bus.cp0_raddr = 5'($urandom);
            endcase
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
